alu_share_arb: RTL and testbench

Two-requester arbiter that time-shares one internal instance of the team's 32-bit ALU. Each requester presents operands and a 3-bit operation code under a valid/ready handshake. Grants alternate round-robin, so one requester cannot starve the other. The granted operation's result and flags are captured in a single registered response slot, tagged with the requester ID and held until the consumer accepts it. The block sits between the issue logic of two execution lanes and the shared ALU.

---
 rtl/alu_share_arb.sv | 150 +++++++++++++++
 tb/tb_alu_share_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-requester round-robin arbiter sharing one 32-bit ALU, one response slot.
// Define ALU_SHARE_ARB_FLAGS_EN to register the zero/minus compare flags.
module alu_share_arb #(
  parameter int RESET_PRIO = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [2:0]  i_req0_ctrl,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [2:0]  i_req1_ctrl,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_zero,
  output logic        o_rsp_minus
);

  localparam logic RR_RST = (RESET_PRIO != 0);

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rr_q, rr_d;

  logic        slot_free;
  logic        gnt0, gnt1, any_gnt;
  logic [31:0] op_a, op_b;
  logic [2:0]  op_ctrl;
  logic [31:0] diff;
  logic [31:0] alu_res;
  logic        sh_big;
  logic [4:0]  sh_amt;

  assign slot_free = !rsp_valid_q || i_rsp_ready;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (slot_free) begin
      unique case (1'b1)
        i_req0_valid && !i_req1_valid:          gnt0 = 1'b1;
        !i_req0_valid && i_req1_valid:          gnt1 = 1'b1;
        i_req0_valid && i_req1_valid && !rr_q:  gnt0 = 1'b1;
        i_req0_valid && i_req1_valid && rr_q:   gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign any_gnt      = gnt0 || gnt1;
  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  assign op_a    = gnt1 ? i_req1_a    : i_req0_a;
  assign op_b    = gnt1 ? i_req1_b    : i_req0_b;
  assign op_ctrl = gnt1 ? i_req1_ctrl : i_req0_ctrl;

  assign diff   = op_a - op_b;
  // Any amount >= 32 shifts everything out.
  assign sh_big = |op_b[31:5];
  assign sh_amt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    unique case (op_ctrl)
      3'b000: alu_res = op_a + op_b;
      3'b001: alu_res = diff;
      3'b010: alu_res = op_a & op_b;
      3'b011: alu_res = op_a | op_b;
      3'b100: alu_res = op_a ^ op_b;
      3'b101: alu_res = sh_big ? {32{op_a[31]}}
                               : $unsigned($signed(op_a) >>> sh_amt);
      3'b110: alu_res = sh_big ? 32'd0 : (op_a >> sh_amt);
      3'b111: alu_res = sh_big ? 32'd0 : (op_a << sh_amt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rr_d        = rr_q;
    if (any_gnt) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt1;
      rsp_data_d  = alu_res;
      rr_d        = gnt0;
    end else if (slot_free) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rr_q        <= RR_RST;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rr_q        <= rr_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;

`ifdef ALU_SHARE_ARB_FLAGS_EN
  logic zero_q, zero_d;
  logic minus_q, minus_d;

  always_comb begin
    zero_d  = zero_q;
    minus_d = minus_q;
    if (any_gnt) begin
      zero_d  = (diff == 32'd0);
      minus_d = diff[31];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zero_q  <= 1'b0;
      minus_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      minus_q <= minus_d;
    end
  end

  assign o_rsp_zero  = zero_q;
  assign o_rsp_minus = minus_q;
`else
  assign o_rsp_zero  = 1'b0;
  assign o_rsp_minus = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed cases plus random traffic
// against a transaction-level reference model.
module tb_alu_share_arb;

  localparam int RP = 0;
`ifdef ALU_SHARE_ARB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 0, v1 = 0;
  logic        rdy0, rdy1;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [2:0]  c0 = 0, c1 = 0;
  logic        rsp_ready = 0;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_minus;
  logic [31:0] rsp_data;

  int n_chk = 0;
  int n_fail = 0;

  // reference state: response slot contents and who wins the next tie
  logic        m_valid, m_id, m_zero, m_minus;
  logic [31:0] m_data;
  int          m_tie;

  always #5 clk = ~clk;

  alu_share_arb #(.RESET_PRIO(RP)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(rdy0),
    .i_req0_a(a0), .i_req0_b(b0), .i_req0_ctrl(c0),
    .i_req1_valid(v1), .o_req1_ready(rdy1),
    .i_req1_a(a1), .i_req1_b(b1), .i_req1_ctrl(c1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .o_rsp_zero(rsp_zero), .o_rsp_minus(rsp_minus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0] c);
    logic signed [31:0] sa;
    sa = a;
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return sa >>> b;
      3'd6: return a >> b;
      default: return a << b;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = 0;
    m_zero = 0; m_minus = 0; m_tie = RP;
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0;
    rst_n = 0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_minus", rsp_minus, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // called at posedge+1 with requests already driven
  task automatic cycle(input logic rr, output int g);
    logic [31:0] d;
    bit free;
    rsp_ready = rr;
    @(negedge clk);
    free = !m_valid || rr;
    g = -1;
    if (free) begin
      if (v0 && v1) g = m_tie;
      else if (v0) g = 0;
      else if (v1) g = 1;
    end
    chk("ready0", rdy0, g == 0);
    chk("ready1", rdy1, g == 1);
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_zero", rsp_zero, m_zero);
    chk("rsp_minus", rsp_minus, m_minus);
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1;
      m_id = (g == 1);
      m_data = (g == 1) ? ref_alu(a1, b1, c1) : ref_alu(a0, b0, c0);
      d = (g == 1) ? a1 - b1 : a0 - b0;
      m_zero = FL && (d == 0);
      m_minus = FL && d[31];
      m_tie = 1 - g;
    end else if (free) begin
      m_valid = 0;
    end
    #1;
  endtask

  function automatic logic [31:0] rnd_b();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 40);
      1: return 32'd32 + $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int g;
    logic [31:0] held_data;
    logic held_id;

    do_reset();

    // single add from requester 0
    v0 = 1; a0 = 5; b0 = 7; c0 = 3'b000;
    cycle(1, g);
    chk("t1_data", rsp_data, 12);
    chk("t1_id", rsp_id, 0);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_zero", rsp_zero, 0);
    chk("t1_minus", rsp_minus, FL);
    v0 = 0;
    cycle(1, g);

    // both valid: grants alternate from the reset priority
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v0 = 1; a0 = 100 + i; b0 = 1; c0 = 0;
      v1 = 1; a1 = 200 + i; b1 = 2; c1 = 1;
      cycle(1, g);
      chk("rr_valid", rsp_valid, 1);
      chk("rr_id", rsp_id, (i % 2 == 0) ? RP : 1 - RP);
    end
    v0 = 0; v1 = 0;
    cycle(1, g);

    // shifts by large amounts from requester 1
    v1 = 1; a1 = 32'h8000_0000; b1 = 4; c1 = 3'b101;
    cycle(1, g);
    chk("sra4", rsp_data, 32'hF800_0000);
    c1 = 3'b110;
    cycle(1, g);
    chk("srl4", rsp_data, 32'h0800_0000);
    b1 = 40;
    cycle(1, g);
    chk("srl40", rsp_data, 0);
    c1 = 3'b101;
    cycle(1, g);
    chk("sra40", rsp_data, 32'hFFFF_FFFF);
    c1 = 3'b111; a1 = 32'h1; b1 = 32;
    cycle(1, g);
    chk("sll32", rsp_data, 0);

    // back-pressure with both requesters waiting
    v0 = 1; a0 = 9; b0 = 3; c0 = 3'b100;
    v1 = 1; a1 = 6; b1 = 6; c1 = 3'b011;
    cycle(1, g);
    held_data = rsp_data;
    held_id = rsp_id;
    for (int i = 0; i < 3; i++) begin
      cycle(0, g);
      chk("bp_rdy0", rdy0, 0);
      chk("bp_rdy1", rdy1, 0);
      chk("bp_data", rsp_data, held_data);
      chk("bp_id", rsp_id, held_id);
    end
    cycle(1, g);
    chk("drain_valid", rsp_valid, 1);
    chk("drain_id", rsp_id, !held_id);

    // reset while a response is pending
    chk("pre_rst_valid", rsp_valid, 1);
    do_reset();
    v0 = 1; a0 = 1; b0 = 1; c0 = 0;
    v1 = 1; a1 = 2; b1 = 2; c1 = 0;
    cycle(1, g);
    chk("post_rst_id", rsp_id, RP);
    v0 = 0; v1 = 0;
    cycle(1, g);

    // equal operands on sub
    v0 = 1; a0 = 32'h7FFF_FFFF; b0 = 32'h7FFF_FFFF; c0 = 3'b001;
    cycle(1, g);
    chk("eq_data", rsp_data, 0);
    chk("eq_zero", rsp_zero, FL);
    chk("eq_minus", rsp_minus, 0);
    v0 = 0;
    cycle(1, g);

    // random traffic; operands change only after a grant
    for (int i = 0; i < 400; i++) begin
      if (!v0 || g == 0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = $urandom; b0 = ($urandom_range(0, 7) == 0) ? a0 : rnd_b();
        c0 = 3'($urandom);
      end
      if (!v1 || g == 1) begin
        v1 = ($urandom_range(0, 3) != 0);
        a1 = $urandom; b1 = ($urandom_range(0, 7) == 0) ? a1 : rnd_b();
        c1 = 3'($urandom);
      end
      cycle(1'($urandom_range(0, 3) != 0), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
